// File: rtl/rf_spi_master_if.sv
// Request/response handshake and SPI pins of the RF SPI master.
// The master modport is the SPI master side; slave is the control FSM plus the SPI device.
interface rf_spi_master_if;
    logic [9:0] addr_in;
    logic [7:0] data_in;
    logic [1:0] inst;
    logic       cs_in;
    logic       ready;
    logic [7:0] data_read;
    logic       read_valid;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       ss_n;

    modport master (
        input  addr_in, data_in, inst, cs_in, miso,
        output ready, data_read, read_valid, sclk, mosi, ss_n
    );

    modport slave (
        output addr_in, data_in, inst, cs_in, miso,
        input  ready, data_read, read_valid, sclk, mosi, ss_n
    );
endinterface

// File: rtl/rf_spi_master.sv
// SPI mode-0 master running one short (16-bit) or long (24-bit) MRF24J40 register
// transaction per cs_in strobe, with lead, trail and gap phases of CLK_DIV cycles each.
module rf_spi_master #(
    parameter int CLK_DIV = 4
) (
    input logic           clk,
    input logic           rst_n,
    rf_spi_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state, state_next;
    logic [7:0]  div_cnt, div_next;
    logic [5:0]  bit_cnt, bit_next;
    logic [23:0] tx_sr, tx_next;
    logic [7:0]  rx_sr, rx_next;
    logic        is_long, is_long_next;
    logic        is_read, is_read_next;
    logic        sclk_q, sclk_next;
    logic        ss_n_q, ss_n_next;
    logic        ready_q, ready_next;
    logic [7:0]  data_read_q, data_read_next;
    logic        read_valid_q, read_valid_next;
    logic        div_done;
    logic        last_bit;
    logic [7:0]  wr_byte;
    logic [23:0] frame;

    // Frames are left-aligned in the TX register so bit 23 is always the bit on MOSI.
    assign wr_byte  = bus.inst[0] ? bus.data_in : 8'h00;
    assign frame    = bus.inst[1] ? {1'b1, bus.addr_in, bus.inst[0], 4'b0000, wr_byte}
                                  : {1'b0, bus.addr_in[5:0], bus.inst[0], wr_byte, 8'h00};
    assign div_done = (div_cnt == DIV_LAST);
    assign last_bit = (bit_cnt == (is_long ? 6'd23 : 6'd15));

    assign bus.sclk       = sclk_q;
    assign bus.mosi       = tx_sr[23];
    assign bus.ss_n       = ss_n_q;
    assign bus.ready      = ready_q;
    assign bus.data_read  = data_read_q;
    assign bus.read_valid = read_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            div_cnt      <= 8'd0;
            bit_cnt      <= 6'd0;
            tx_sr        <= 24'd0;
            rx_sr        <= 8'd0;
            is_long      <= 1'b0;
            is_read      <= 1'b0;
            sclk_q       <= 1'b0;
            ss_n_q       <= 1'b1;
            ready_q      <= 1'b1;
            data_read_q  <= 8'h00;
            read_valid_q <= 1'b0;
        end else begin
            state        <= state_next;
            div_cnt      <= div_next;
            bit_cnt      <= bit_next;
            tx_sr        <= tx_next;
            rx_sr        <= rx_next;
            is_long      <= is_long_next;
            is_read      <= is_read_next;
            sclk_q       <= sclk_next;
            ss_n_q       <= ss_n_next;
            ready_q      <= ready_next;
            data_read_q  <= data_read_next;
            read_valid_q <= read_valid_next;
        end
    end

    always_comb begin
        state_next      = state;
        div_next        = div_cnt;
        bit_next        = bit_cnt;
        tx_next         = tx_sr;
        rx_next         = rx_sr;
        is_long_next    = is_long;
        is_read_next    = is_read;
        sclk_next       = sclk_q;
        ss_n_next       = ss_n_q;
        ready_next      = ready_q;
        data_read_next  = data_read_q;
        read_valid_next = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cs_in && ready_q) begin
                    state_next   = LEAD;
                    div_next     = 8'd0;
                    bit_next     = 6'd0;
                    tx_next      = frame;
                    is_long_next = bus.inst[1];
                    is_read_next = !bus.inst[0];
                    ss_n_next    = 1'b0;
                    ready_next   = 1'b0;
                end
            end
            LEAD: begin
                if (div_done) begin
                    state_next = SHIFT;
                    div_next   = 8'd0;
                    sclk_next  = 1'b1;
                    if (is_read) rx_next = {rx_sr[6:0], bus.miso};
                end else begin
                    div_next = div_cnt + 8'd1;
                end
            end
            SHIFT: begin
                if (!div_done) begin
                    div_next = div_cnt + 8'd1;
                end else begin
                    div_next = 8'd0;
                    if (!sclk_q) begin
                        sclk_next = 1'b1;
                        if (is_read) rx_next = {rx_sr[6:0], bus.miso};
                    end else begin
                        sclk_next = 1'b0;
                        // The final falling edge leaves MOSI alone and closes the frame.
                        if (last_bit) begin
                            state_next = TRAIL;
                            bit_next   = 6'd0;
                        end else begin
                            bit_next = bit_cnt + 6'd1;
                            tx_next  = {tx_sr[22:0], 1'b0};
                        end
                    end
                end
            end
            TRAIL: begin
                if (div_done) begin
                    state_next = GAP;
                    div_next   = 8'd0;
                    ss_n_next  = 1'b1;
                    tx_next    = 24'd0;
                end else begin
                    div_next = div_cnt + 8'd1;
                end
            end
            GAP: begin
                if (div_done) begin
                    state_next = IDLE;
                    div_next   = 8'd0;
                    ready_next = 1'b1;
                    if (is_read) begin
                        data_read_next  = rx_sr;
                        read_valid_next = 1'b1;
                    end
                end else begin
                    div_next = div_cnt + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rf_spi_master.sv
// Scoreboard bench for rf_spi_master: frames are queued when strobed and checked
// bit-for-bit and cycle-for-cycle when the master returns to ready.
module tb_rf_spi_master;
    localparam int H = 4;

    typedef struct {
        logic [23:0] frame;
        int          n;
        bit          is_read;
        logic [7:0]  rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    int          slave_idx = 0;
    int          slave_n = 16;
    logic [7:0]  slave_byte = 8'h00;
    logic [7:0]  last_rd = 8'h00;
    logic [9:0]  r_addr;
    logic [7:0]  r_data;
    logic [7:0]  r_byte;
    logic [1:0]  r_inst;
    int          extra_frames;

    rf_spi_master_if bus();

    rf_spi_master #(.CLK_DIV(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Slave device: header bits read back as 1s, data byte MSB first, changes on SCLK fall.
    function automatic logic slaveBit(input int i, input int n, input logic [7:0] b);
        if (i >= n) return 1'b0;
        if (i < n - 8) return 1'b1;
        return b[n - 1 - i];
    endfunction

    always @(posedge bus.ss_n or negedge bus.sclk) begin
        if (bus.ss_n) slave_idx = 0;
        else slave_idx = slave_idx + 1;
    end

    assign bus.miso = bus.ss_n ? 1'b0 : slaveBit(slave_idx, slave_n, slave_byte);

    function automatic logic [23:0] modelFrame(input logic [9:0] a, input logic [7:0] d,
                                               input logic [1:0] ins);
        logic [7:0] db;
        db = ins[0] ? d : 8'h00;
        if (ins[1]) return {1'b1, a, ins[0], 4'b0000, db};
        return {8'h00, 1'b0, a[5:0], ins[0], db};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Called at a falling clk edge; strobes for exactly one cycle then scrambles the inputs.
    task automatic applyStimulus(input logic [9:0] a, input logic [7:0] d, input logic [1:0] ins,
                                 input logic [7:0] sbyte, input logic [23:0] frame_exp);
        exp_t e;
        slave_byte = sbyte;
        slave_n    = ins[1] ? 24 : 16;
        e.frame    = frame_exp;
        e.n        = slave_n;
        e.is_read  = !ins[0];
        e.rdata    = ins[0] ? last_rd : sbyte;
        sb.push_back(e);
        bus.addr_in = a;
        bus.data_in = d;
        bus.inst    = ins;
        bus.cs_in   = 1'b1;
        @(negedge clk);
        bus.cs_in   = 1'b0;
        bus.addr_in = 10'($urandom);
        bus.data_in = 8'($urandom);
        bus.inst    = 2'($urandom);
    endtask

    task automatic observeFrame(input int cs_at, input int rst_at);
        exp_t        e;
        logic [23:0] got = 24'd0;
        int          rises = 0, first_rise = -1, ss_rise = -1, ready_cyc = -1;
        int          rv_seen = 0, bad_phase = 0, phase = 0;
        logic        prev_sclk = 1'b0, rv_at_ready = 1'b0;
        logic [7:0]  rd_at_ready = 8'h00;
        bit          aborted = 1'b0;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            if (cyc == 1) begin
                checkOutput("ss_n_fall", 32'(bus.ss_n), 0);
                checkOutput("ready_fall", 32'(bus.ready), 0);
            end
            if (cyc == cs_at) begin
                bus.addr_in = 10'h3FF;
                bus.data_in = 8'hFF;
                bus.inst    = 2'b01;
                bus.cs_in   = 1'b1;
            end else begin
                bus.cs_in = 1'b0;
            end
            if (bus.sclk !== prev_sclk) begin
                if (phase != H) bad_phase++;
                phase = 0;
            end
            phase++;
            if (bus.sclk && !prev_sclk) begin
                got = {got[22:0], bus.mosi};
                rises++;
                if (rises == 1) first_rise = cyc;
            end
            if (cyc > 1 && bus.ss_n && ss_rise < 0) ss_rise = cyc;
            if (bus.read_valid) rv_seen++;
            if (bus.ready) begin
                ready_cyc   = cyc;
                rd_at_ready = bus.data_read;
                rv_at_ready = bus.read_valid;
            end
            prev_sclk = bus.sclk;
            if (rst_at > 0 && rises == rst_at) begin
                rst_n = 1'b0;
                #1;
                checkOutput("rst_ss_n", 32'(bus.ss_n), 1);
                checkOutput("rst_sclk", 32'(bus.sclk), 0);
                checkOutput("rst_ready", 32'(bus.ready), 1);
                checkOutput("rst_mosi", 32'(bus.mosi), 0);
                checkOutput("rst_data_read", 32'(bus.data_read), 0);
                if (sb.size() > 0) void'(sb.pop_front());
                last_rd = 8'h00;
                @(negedge clk);
                rst_n = 1'b1;
                rv_seen = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (bus.read_valid) rv_seen++;
                end
                checkOutput("rst_no_read_valid", rv_seen, 0);
                aborted = 1'b1;
                break;
            end
            if (ready_cyc >= 0) break;
            @(negedge clk);
        end
        if (aborted) return;
        if (ready_cyc < 0) begin
            checkOutput("ready_timeout", 0, 1);
            return;
        end
        if (sb.size() == 0) begin
            checkOutput("scoreboard_underflow", 1, 0);
            return;
        end
        e = sb.pop_front();
        checkOutput("mosi_frame", 32'(got), 32'(e.frame));
        checkOutput("sclk_pulses", rises, e.n);
        checkOutput("first_rise", first_rise, 1 + H);
        checkOutput("ss_n_rise", ss_rise, 1 + 2 * e.n * H + H);
        checkOutput("ready_rise", ready_cyc, 1 + (2 * e.n + 2) * H);
        checkOutput("phase_len", bad_phase, 0);
        checkOutput("read_valid_count", rv_seen, 32'(e.is_read));
        checkOutput("read_valid_at_ready", 32'(rv_at_ready), 32'(e.is_read));
        checkOutput("data_read", 32'(rd_at_ready), 32'(e.rdata));
        if (e.is_read) last_rd = e.rdata;
    endtask

    initial begin
        bus.cs_in   = 1'b0;
        bus.addr_in = 10'd0;
        bus.data_in = 8'd0;
        bus.inst    = 2'd0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", 32'(bus.ready), 1);
        checkOutput("reset_ss_n", 32'(bus.ss_n), 1);
        checkOutput("reset_sclk", 32'(bus.sclk), 0);
        checkOutput("reset_mosi", 32'(bus.mosi), 0);
        checkOutput("reset_read_valid", 32'(bus.read_valid), 0);
        checkOutput("reset_data_read", 32'(bus.data_read), 0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(10'h036, 8'h04, 2'b01, 8'hFF, 24'h006D04);
        observeFrame(0, 0);
        repeat (2) @(negedge clk);
        applyStimulus(10'h031, 8'h77, 2'b00, 8'hA5, 24'h006200);
        observeFrame(0, 0);
        // Strobe on the very cycle ready rises.
        applyStimulus(10'h200, 8'h5A, 2'b11, 8'h81, 24'hC0105A);
        observeFrame(0, 0);
        repeat (3) @(negedge clk);
        applyStimulus(10'h207, 8'h99, 2'b10, 8'h3C, 24'hC0E000);
        observeFrame(0, 0);

        repeat (2) @(negedge clk);
        applyStimulus(10'h155, 8'hC3, 2'b01, 8'h00, modelFrame(10'h155, 8'hC3, 2'b01));
        observeFrame(40, 0);
        extra_frames = 0;
        repeat (60) begin
            @(negedge clk);
            if (!bus.ss_n) extra_frames++;
        end
        checkOutput("ignored_cs_no_frame", extra_frames, 0);

        for (int i = 0; i < 4; i++) begin
            r_addr = 10'($urandom);
            r_data = 8'($urandom);
            r_inst = 2'($urandom);
            r_byte = 8'($urandom);
            applyStimulus(r_addr, r_data, r_inst, r_byte, modelFrame(r_addr, r_data, r_inst));
            observeFrame(0, 0);
            @(negedge clk);
        end

        applyStimulus(10'h207, 8'h00, 2'b10, 8'h3C, 24'hC0E000);
        observeFrame(0, 10);
        applyStimulus(10'h031, 8'h00, 2'b00, 8'h5E, 24'h006200);
        observeFrame(0, 0);

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
